// File: rtl/uart_tx_drain.sv
// UART transmitter that pulls bytes from an upstream FIFO and sends them LSB first.
// Define UART_TX_PARITY_EN to add an even-parity bit between the data and stop bits.
module uart_tx_drain #(
    parameter int CLKS_PER_BIT = 868,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_dout,
    output logic       fifo_deq,
    output logic       tx,
    output logic       busy
);
    localparam int            CW        = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t        state, state_next;
    logic [CW-1:0] baud_cnt, baud_next;
    logic [2:0]    bit_idx, idx_next;
    logic          stop_cnt, stop_next;
    logic [7:0]    shift_reg, shift_next;
    logic          tx_next;
    logic          bit_done;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            baud_cnt  <= '0;
            bit_idx   <= '0;
            stop_cnt  <= 1'b0;
            shift_reg <= '0;
            tx        <= 1'b1;
        end else begin
            state     <= state_next;
            baud_cnt  <= baud_next;
            bit_idx   <= idx_next;
            stop_cnt  <= stop_next;
            shift_reg <= shift_next;
            tx        <= tx_next;
        end
    end

    // tx is registered, so its next value is decoded from the next state and next bit index.
    always_comb begin
        state_next = state;
        baud_next  = baud_cnt;
        idx_next   = bit_idx;
        stop_next  = stop_cnt;
        shift_next = shift_reg;
        fifo_deq   = 1'b0;
        bit_done   = (baud_cnt == BAUD_LAST);

        if (state != IDLE) begin
            baud_next = bit_done ? '0 : baud_cnt + CW'(1);
        end

        case (state)
            IDLE: begin
                baud_next = '0;
                idx_next  = '0;
                stop_next = 1'b0;
                if (en && !fifo_empty && rst_n) begin
                    fifo_deq   = 1'b1;
                    shift_next = fifo_dout;
                    state_next = START;
                end
            end
            START: begin
                if (bit_done) state_next = DATA;
            end
            DATA: begin
                if (bit_done) begin
                    if (bit_idx == 3'd7) begin
                        idx_next = '0;
`ifdef UART_TX_PARITY_EN
                        state_next = PARITY;
`else
                        state_next = STOP;
`endif
                    end else begin
                        idx_next = bit_idx + 3'd1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_done) state_next = STOP;
            end
`endif
            STOP: begin
                if (bit_done) begin
                    if (stop_cnt == STOP_LAST) state_next = IDLE;
                    else                        stop_next  = stop_cnt + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase

        case (state_next)
            START:   tx_next = 1'b0;
            DATA:    tx_next = shift_next[idx_next];
`ifdef UART_TX_PARITY_EN
            PARITY:  tx_next = ^shift_next;
`endif
            default: tx_next = 1'b1;
        endcase
    end

    assign busy = (state != IDLE);

endmodule
